coproc_arbiter: RTL and testbench
=================================

COPROC_ARBITER -- requirements
Module: coproc_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1000, which is the number of WAIT cycles before a job is aborted (legal range 1..65535).
REQ-002 The block SHALL have port clk, input, 1 bit: the clock; all logic is on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have ports reqN_valid (input, 1 bit, N=0,1): requester N has a job pending.
REQ-005 The block SHALL have ports reqN_op (input, 3 bits), reqN_size (input, 2 bits) and reqN_scalar (input, 8 bits): requester N's job descriptor.
REQ-006 The block SHALL have ports reqN_ready (output, 1 bit): the job is accepted in the cycle where reqN_valid and reqN_ready are both high.
REQ-007 The block SHALL have ports cp_op_code (output, 3 bits), cp_matrix_size (output, 2 bits) and cp_scalar (output, 8 bits): the descriptor driven to the coprocessor.
REQ-008 The block SHALL have port cp_sel, output, 1 bit: which requester's matrix bank feeds the datapath.
REQ-009 The block SHALL have port cp_start, output, 1 bit: a one-cycle launch pulse.
REQ-010 The block SHALL have ports cp_done (input, 1 bit) and cp_overflow (input, 1 bit): coprocessor completion and overflow status.
REQ-011 The block SHALL have outputs rsp_valid (1 bit), rsp_id (1 bit), rsp_overflow (1 bit) and rsp_timeout (1 bit), and input rsp_ready (1 bit): the result handshake.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESPOND.
REQ-014 Ready generation SHALL be combinational: reqN_ready is high only in IDLE and only for the requester selected by REQ-015.
REQ-015 Arbitration SHALL be round-robin.
- One requester valid: that requester is granted.
- Both valid: the requester not granted last time is granted.
- After reset, req0 has priority.
REQ-016 On acceptance at cycle T, the block SHALL register the descriptor, cp_sel and the granted id, and go to ISSUE.
- cp_start is high for exactly cycle T+1.
- WAIT is entered at T+2.
REQ-017 cp_op_code, cp_matrix_size, cp_scalar and cp_sel SHALL hold the captured values from T+1 until RESPOND exits, and SHALL hold their last value in IDLE.
REQ-018 cp_done SHALL be sampled only in WAIT; a cp_done seen in IDLE, ISSUE or RESPOND is ignored.
REQ-019 On cp_done in WAIT, the block SHALL capture cp_overflow into rsp_overflow, clear rsp_timeout and go to RESPOND.
REQ-020 In RESPOND, rsp_valid SHALL be high, and rsp_id, rsp_overflow and rsp_timeout SHALL be stable until rsp_ready is high.
- On the handshake cycle the FSM goes to IDLE.
- rsp_valid is low from the next cycle.
REQ-021 A new request SHALL NOT be accepted in the cycle the response completes; the earliest acceptance is one cycle later.
REQ-022 Requests arriving while busy SHALL stall on reqN_ready=0 and SHALL NOT be lost or reordered per requester.
REQ-023 Latency SHALL be as follows: best case acceptance to rsp_valid is 3 cycles (cp_done high on the first WAIT cycle).

Reset
REQ-024 On reset assertion, the block SHALL go to IDLE immediately and asynchronously, including mid-job.
- cp_start, rsp_valid, rsp_overflow, rsp_timeout, rsp_id, cp_sel and busy are 0.
- cp_op_code, cp_matrix_size and cp_scalar are 0.
- The round-robin pointer is set to give req0 priority.
- The timeout counter is 0.
REQ-025 An aborted job SHALL produce no response, and a cp_done arriving after reset deassertion SHALL be ignored (REQ-018).

Configuration
REQ-026 The macro COPROC_TIMEOUT_EN SHALL control the timeout watchdog.
- Defined: a 16-bit counter clears on WAIT entry and increments each WAIT cycle without cp_done.
- Defined: if the counter reaches TIMEOUT_CYCLES, the FSM goes to RESPOND with rsp_timeout=1 and rsp_overflow=0.
- Defined: cp_done and expiry in the same cycle resolve as done (rsp_timeout=0).
- Not defined: there is no counter, rsp_timeout is tied to 0, and WAIT persists until cp_done.

Verification
REQ-027 Single job: req0_valid, op=3, size=2, scalar=5, with cp_done 4 cycles after cp_start and cp_overflow=1 -> one cp_start pulse, cp_op_code=3, rsp_valid with rsp_id=0, rsp_overflow=1, rsp_timeout=0.
REQ-028 Contention: req0 and req1 held valid for 4 jobs -> grant order 0,1,0,1 and cp_sel tracks each grant.
REQ-029 Backpressure: rsp_ready held low for 10 cycles -> rsp_valid and its fields are stable for all 10 cycles, then the FSM returns to IDLE one cycle after rsp_ready.
REQ-030 Timeout (COPROC_TIMEOUT_EN, TIMEOUT_CYCLES=8), with cp_done never asserted -> rsp_timeout=1 and rsp_overflow=0 after exactly 8 WAIT cycles.
REQ-031 Timeout tie: cp_done asserted on the WAIT cycle where the count reaches 8 -> rsp_timeout=0.
REQ-032 Reset mid-WAIT: reset pulsed, then a stray cp_done arrives -> rsp_valid stays 0, busy=0, and the next req1 job completes normally.

Source files
------------

// File: rtl/coproc_arbiter.sv
// rtl/coproc_arbiter.sv - two-requester round-robin job arbiter for a matrix coprocessor
//
// Optional feature: define COPROC_TIMEOUT_EN to build the WAIT-state watchdog.
//
// Ports:
//   clk, reset                       rising-edge clock, asynchronous active-high reset
//   req0_*/req1_*                    job requests: valid/ready handshake, op/size/scalar descriptor
//   cp_op_code, cp_matrix_size,
//   cp_scalar, cp_sel, cp_start      descriptor, bank select and launch pulse to the coprocessor
//   cp_done, cp_overflow             coprocessor completion and overflow status
//   rsp_valid/rsp_ready              result handshake; rsp_id, rsp_overflow, rsp_timeout qualify it
//   busy                             high whenever a job is in flight or a response is pending
module coproc_arbiter #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [2:0] req0_op,
  input  logic [1:0] req0_size,
  input  logic [7:0] req0_scalar,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [2:0] req1_op,
  input  logic [1:0] req1_size,
  input  logic [7:0] req1_scalar,
  output logic       req1_ready,
  output logic [2:0] cp_op_code,
  output logic [1:0] cp_matrix_size,
  output logic [7:0] cp_scalar,
  output logic       cp_sel,
  output logic       cp_start,
  input  logic       cp_done,
  input  logic       cp_overflow,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic       rsp_overflow,
  output logic       rsp_timeout,
  input  logic       rsp_ready,
  output logic       busy
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("coproc_arbiter: TIMEOUT_CYCLES out of range 1..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESPOND
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       rr_last;      // id granted most recently; reset to 1 so req0 wins the first tie
  logic       grant_id;
  logic       accept;
  logic       done_hit;
  logic       timeout_hit;
  logic       id_q;
  logic [2:0] op_q;
  logic [1:0] size_q;
  logic [7:0] scalar_q;
  logic       overflow_q;

  // Round-robin pick: a lone requester always wins, a tie goes to the one not served last.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~rr_last;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign req0_ready = (state == ST_IDLE) && req0_valid && !grant_id;
  assign req1_ready = (state == ST_IDLE) && req1_valid &&  grant_id;
  assign accept     = req0_ready | req1_ready;
  assign done_hit   = (state == ST_WAIT) && cp_done;

`ifdef COPROC_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_cnt;
  logic        timeout_q;

  // Counter holds the number of completed WAIT cycles; expiry fires on the
  // WAIT cycle that would bring it to TIMEOUT_CYCLES, unless cp_done wins.
  assign timeout_hit = (state == ST_WAIT) && !cp_done && (wait_cnt == TIMEOUT_LAST);
  assign rsp_timeout = timeout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt  <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      if (state == ST_ISSUE) begin
        wait_cnt <= 16'd0;
      end else if ((state == ST_WAIT) && !cp_done) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
      if (done_hit) begin
        timeout_q <= 1'b0;
      end else if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (accept) state_nxt = ST_ISSUE;
      ST_ISSUE:   state_nxt = ST_WAIT;
      ST_WAIT:    if (done_hit || timeout_hit) state_nxt = ST_RESPOND;
      ST_RESPOND: if (rsp_ready) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Descriptor and id are captured at acceptance and held until the next one,
  // so the coprocessor inputs stay stable through the whole job and after it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last    <= 1'b1;
      id_q       <= 1'b0;
      op_q       <= 3'd0;
      size_q     <= 2'd0;
      scalar_q   <= 8'd0;
      overflow_q <= 1'b0;
    end else begin
      if (accept) begin
        rr_last  <= grant_id;
        id_q     <= grant_id;
        op_q     <= grant_id ? req1_op     : req0_op;
        size_q   <= grant_id ? req1_size   : req0_size;
        scalar_q <= grant_id ? req1_scalar : req0_scalar;
      end
      if (done_hit) begin
        overflow_q <= cp_overflow;
      end else if (timeout_hit) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign cp_op_code     = op_q;
  assign cp_matrix_size = size_q;
  assign cp_scalar      = scalar_q;
  assign cp_sel         = id_q;
  assign cp_start       = (state == ST_ISSUE);
  assign rsp_valid      = (state == ST_RESPOND);
  assign rsp_id         = id_q;
  assign rsp_overflow   = overflow_q;
  assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_coproc_arbiter.sv
// tb/tb_coproc_arbiter.sv - directed self-checking bench for coproc_arbiter
module tb_coproc_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [2:0] req0_op, req1_op;
  logic [1:0] req0_size, req1_size;
  logic [7:0] req0_scalar, req1_scalar;
  logic       req0_ready, req1_ready;
  logic [2:0] cp_op_code;
  logic [1:0] cp_matrix_size;
  logic [7:0] cp_scalar;
  logic       cp_sel, cp_start, cp_done, cp_overflow;
  logic       rsp_valid, rsp_id, rsp_overflow, rsp_timeout, rsp_ready, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_start = 0;

  coproc_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_size(req0_size),
    .req0_scalar(req0_scalar), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_size(req1_size),
    .req1_scalar(req1_scalar), .req1_ready(req1_ready),
    .cp_op_code(cp_op_code), .cp_matrix_size(cp_matrix_size), .cp_scalar(cp_scalar),
    .cp_sel(cp_sel), .cp_start(cp_start), .cp_done(cp_done), .cp_overflow(cp_overflow),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_overflow(rsp_overflow),
    .rsp_timeout(rsp_timeout), .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cp_start) n_start++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] exp_desc(input logic id);
    return id ? {3'd6, 2'd1, 8'hA5} : {3'd3, 2'd2, 8'd5};
  endfunction

  // Runs one job from an IDLE cycle where the winning request is already valid.
  task automatic job(input logic exp_id, input int done_delay, input logic ovf,
                     input int bp, input logic drop);
    #1;
    chk("ready_grant", {req1_ready, req0_ready}, exp_id ? 2'b10 : 2'b01);
    step();
    if (drop) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    chk("start_pulse", cp_start, 1'b1);
    chk("cp_sel", cp_sel, exp_id);
    chk("desc", {cp_op_code, cp_matrix_size, cp_scalar}, exp_desc(exp_id));
    step();
    chk("start_low", cp_start, 1'b0);
    repeat (done_delay) step();
    cp_done = 1'b1;
    cp_overflow = ovf;
    step();
    cp_done = 1'b0;
    cp_overflow = 1'b0;
    chk("rsp", {rsp_valid, rsp_id, rsp_overflow, rsp_timeout}, {1'b1, exp_id, ovf, 1'b0});
    for (int i = 0; i < bp; i++) begin
      chk("rsp_hold", {rsp_valid, rsp_id, rsp_overflow, rsp_timeout, busy},
          {1'b1, exp_id, ovf, 1'b0, 1'b1});
      chk("desc_hold", {cp_op_code, cp_matrix_size, cp_scalar, cp_sel},
          {exp_desc(exp_id), exp_id});
      step();
    end
    rsp_ready = 1'b1;
    chk("no_accept_respond", {req1_ready, req0_ready}, 2'b00);
    step();
    rsp_ready = 1'b0;
    chk("back_idle", {rsp_valid, busy}, 2'b00);
    chk("desc_idle_hold", {cp_op_code, cp_matrix_size, cp_scalar}, exp_desc(exp_id));
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = 3'd3; req0_size = 2'd2; req0_scalar = 8'd5;
    req1_op = 3'd6; req1_size = 2'd1; req1_scalar = 8'hA5;
    cp_done = 1'b0; cp_overflow = 1'b0; rsp_ready = 1'b0;
    step();
    step();
    chk("reset_ctrl", {busy, cp_start, rsp_valid, rsp_id, rsp_overflow, rsp_timeout, cp_sel}, 7'd0);
    chk("reset_desc", {cp_op_code, cp_matrix_size, cp_scalar}, 13'd0);
    chk("reset_ready", {req1_ready, req0_ready}, 2'b00);
    reset = 1'b0;
    step();

    // single job, cp_done four cycles after cp_start, overflow reported
    req0_valid = 1'b1;
    job(1'b0, 3, 1'b1, 0, 1'b1);

    // contention right after reset: 0,1,0,1
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    job(1'b0, 0, 1'b0, 0, 1'b0);
    job(1'b1, 0, 1'b1, 0, 1'b0);
    job(1'b0, 1, 1'b0, 0, 1'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req1_valid = 1'b1;
    job(1'b1, 2, 1'b0, 0, 1'b1);

    // backpressure: ten cycles of rsp_ready low
    step();
    req1_valid = 1'b1;
    job(1'b1, 0, 1'b1, 10, 1'b1);

`ifdef COPROC_TIMEOUT_EN
    // watchdog expiry after exactly 8 WAIT cycles
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    step();
    cp_overflow = 1'b1;
    repeat (7) step();
    chk("to_still_wait", {rsp_valid, busy}, 2'b01);
    step();
    cp_overflow = 1'b0;
    chk("to_rsp", {rsp_valid, rsp_id, rsp_overflow, rsp_timeout}, 4'b1001);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // cp_done on the expiry cycle resolves as done
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    step();
    repeat (7) step();
    cp_done = 1'b1;
    cp_overflow = 1'b1;
    step();
    cp_done = 1'b0;
    cp_overflow = 1'b0;
    chk("tie_rsp", {rsp_valid, rsp_id, rsp_overflow, rsp_timeout}, 4'b1010);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
`else
    // without the watchdog WAIT persists until cp_done
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    step();
    repeat (20) step();
    chk("no_to_wait", {rsp_valid, busy}, 2'b01);
    cp_done = 1'b1;
    cp_overflow = 1'b0;
    step();
    cp_done = 1'b0;
    chk("no_to_rsp", {rsp_valid, rsp_id, rsp_overflow, rsp_timeout}, 4'b1000);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    step();
    cp_done = 1'b1;
    cp_overflow = 1'b1;
    step();
    cp_done = 1'b0;
    cp_overflow = 1'b0;
    chk("ovf_rsp", {rsp_valid, rsp_id, rsp_overflow, rsp_timeout}, 4'b1010);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
`endif

    // reset in the middle of WAIT, then a stray cp_done
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    chk("async_reset_ctrl", {busy, rsp_valid, cp_start, cp_sel, rsp_id, rsp_overflow, rsp_timeout}, 7'd0);
    chk("async_reset_desc", {cp_op_code, cp_matrix_size, cp_scalar}, 13'd0);
    step();
    reset = 1'b0;
    cp_done = 1'b1;
    cp_overflow = 1'b1;
    step();
    cp_done = 1'b0;
    cp_overflow = 1'b0;
    chk("stray_done", {rsp_valid, busy}, 2'b00);
    step();
    chk("stray_done_late", {rsp_valid, busy}, 2'b00);

    req1_valid = 1'b1;
    job(1'b1, 1, 1'b1, 0, 1'b1);

    step();
    chk("start_pulses", n_start, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
